ram_sp_rdmode: RTL and testbench



---
 rtl/ram_sp_rdmode_pkg.sv | 14 +
 rtl/ram_sp_core.sv | 40 ++++
 rtl/ram_sp_rdmode.sv | 113 +++++++++++
 tb/tb_ram_sp_rdmode.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sp_rdmode_pkg.sv
// Shared encodings for the single-port RAM with selectable
// read-during-write behaviour and post-reset clear sweep.
package ram_sp_rdmode_pkg;

    localparam int RD_FIRST  = 0;
    localparam int WR_FIRST  = 1;
    localparam int NO_CHANGE = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/ram_sp_core.sv
// Bare memory array: one synchronous write port and a combinational
// read with read-first / write-first selection; out-of-range reads give 0.
module ram_sp_core
    import ram_sp_rdmode_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 32,
    parameter int READ_MODE = RD_FIRST
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] di,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;

    assign in_range = 32'(addr) < DEPTH;

    always_ff @(posedge clk) begin
        if (wr_en && in_range) begin
            mem[addr] <= di;
        end
    end

    always_comb begin
        rd_data = '0;
        if (in_range) begin
            if (READ_MODE == WR_FIRST && wr_en) begin
                rd_data = di;
            end else begin
                rd_data = mem[addr];
            end
        end
    end

endmodule

// File: rtl/ram_sp_rdmode.sv
// Single-port synchronous RAM top: access qualifier, no-change hold,
// optional output register, do_valid strobe and post-reset clear FSM.
module ram_sp_rdmode
    import ram_sp_rdmode_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 32,
    parameter int READ_MODE    = RD_FIRST,
    parameter int OUT_REG      = 0,
    parameter int CLEAR_ON_RST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] di,
    output logic [DATA_W-1:0] dout,
    output logic              do_valid,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] do_q, do_d;
    logic              vld_q, vld_d;

    logic              acc;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_di;
    logic [DATA_W-1:0] rd_data;

    assign busy = (state_q == ST_CLEAR);
    assign acc  = en & ~busy;

    // Reset wins over both the sweep and a client write in the same cycle.
    assign core_we   = ~rst & (busy | (acc & we));
    assign core_addr = busy ? cnt_q : addr;
    assign core_di   = busy ? '0 : di;

    ram_sp_core #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .READ_MODE (READ_MODE)
    ) u_core (
        .clk     (clk),
        .wr_en   (core_we),
        .addr    (core_addr),
        .di      (core_di),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        do_d  = do_q;
        vld_d = 1'b0;
        if (acc && !(we && READ_MODE == NO_CHANGE)) begin
            do_d  = rd_data;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
            do_q    <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            do_q    <= do_d;
            vld_q   <= vld_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] pipe_q;
        logic              pipe_vld_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                pipe_q     <= '0;
                pipe_vld_q <= 1'b0;
            end else begin
                pipe_q     <= do_q;
                pipe_vld_q <= vld_q;
            end
        end

        assign dout     = pipe_q;
        assign do_valid = pipe_vld_q;
    end else begin : g_no_out_reg
        assign dout     = do_q;
        assign do_valid = vld_q;
    end

endmodule

// File: tb/tb_ram_sp_rdmode.sv
// Six RAM configurations driven in lockstep against a reference model
// whose expected outputs are queued per instance and popped each edge.
module tb_ram_sp_rdmode;

    localparam int N = 6;
    localparam int P_RM [N] = '{0, 1, 2, 0, 0, 0};
    localparam int P_OR [N] = '{0, 0, 0, 1, 0, 0};
    localparam int P_CL [N] = '{0, 0, 0, 0, 1, 0};
    localparam int P_DP [N] = '{32, 32, 32, 32, 32, 20};

    typedef struct {
        logic [3:0] d;
        logic       v;
        bit         chk;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]      rst, en, we, dv, busy;
    logic [N-1:0][4:0] addr;
    logic [N-1:0][3:0] di, dout;

    logic [3:0] mmem  [N][32];
    bit         mkn   [N][32];
    logic [3:0] mhold [N];
    bit         mhk   [N];
    bit         mbusy [N];
    int         mcnt  [N];
    exp_t       sbq   [N][$];

    int nerr = 0;
    int nchk = 0;
    int bcnt;

    ram_sp_rdmode #(.READ_MODE(P_RM[0]), .OUT_REG(P_OR[0]),
                    .CLEAR_ON_RST(P_CL[0]), .DEPTH(P_DP[0])) u0 (
        .clk(clk), .rst(rst[0]), .en(en[0]), .we(we[0]), .addr(addr[0]),
        .di(di[0]), .dout(dout[0]), .do_valid(dv[0]), .busy(busy[0]));
    ram_sp_rdmode #(.READ_MODE(P_RM[1]), .OUT_REG(P_OR[1]),
                    .CLEAR_ON_RST(P_CL[1]), .DEPTH(P_DP[1])) u1 (
        .clk(clk), .rst(rst[1]), .en(en[1]), .we(we[1]), .addr(addr[1]),
        .di(di[1]), .dout(dout[1]), .do_valid(dv[1]), .busy(busy[1]));
    ram_sp_rdmode #(.READ_MODE(P_RM[2]), .OUT_REG(P_OR[2]),
                    .CLEAR_ON_RST(P_CL[2]), .DEPTH(P_DP[2])) u2 (
        .clk(clk), .rst(rst[2]), .en(en[2]), .we(we[2]), .addr(addr[2]),
        .di(di[2]), .dout(dout[2]), .do_valid(dv[2]), .busy(busy[2]));
    ram_sp_rdmode #(.READ_MODE(P_RM[3]), .OUT_REG(P_OR[3]),
                    .CLEAR_ON_RST(P_CL[3]), .DEPTH(P_DP[3])) u3 (
        .clk(clk), .rst(rst[3]), .en(en[3]), .we(we[3]), .addr(addr[3]),
        .di(di[3]), .dout(dout[3]), .do_valid(dv[3]), .busy(busy[3]));
    ram_sp_rdmode #(.READ_MODE(P_RM[4]), .OUT_REG(P_OR[4]),
                    .CLEAR_ON_RST(P_CL[4]), .DEPTH(P_DP[4])) u4 (
        .clk(clk), .rst(rst[4]), .en(en[4]), .we(we[4]), .addr(addr[4]),
        .di(di[4]), .dout(dout[4]), .do_valid(dv[4]), .busy(busy[4]));
    ram_sp_rdmode #(.READ_MODE(P_RM[5]), .OUT_REG(P_OR[5]),
                    .CLEAR_ON_RST(P_CL[5]), .DEPTH(P_DP[5])) u5 (
        .clk(clk), .rst(rst[5]), .en(en[5]), .we(we[5]), .addr(addr[5]),
        .di(di[5]), .dout(dout[5]), .do_valid(dv[5]), .busy(busy[5]));

    task automatic model_edge(int k);
        exp_t r;
        int   a;
        bit   inr;
        a   = int'(addr[k]);
        inr = a < P_DP[k];
        if (rst[k]) begin
            sbq[k].delete();
            r.d   = '0;
            r.v   = 1'b0;
            r.chk = 1'b1;
            for (int i = 0; i <= P_OR[k]; i++) sbq[k].push_back(r);
            mhold[k] = '0;
            mhk[k]   = 1'b1;
            mbusy[k] = (P_CL[k] != 0);
            mcnt[k]  = 0;
            return;
        end
        r.d   = mhold[k];
        r.v   = 1'b0;
        r.chk = mhk[k];
        if (en[k] && !mbusy[k]) begin
            if (!we[k]) begin
                r.v   = 1'b1;
                r.d   = inr ? mmem[k][a] : 4'h0;
                r.chk = !inr || mkn[k][a];
            end else if (P_RM[k] == 0) begin
                r.v   = 1'b1;
                r.d   = inr ? mmem[k][a] : 4'h0;
                r.chk = inr && mkn[k][a];
            end else if (P_RM[k] == 1) begin
                r.v   = 1'b1;
                r.d   = di[k];
                r.chk = inr;
            end
            if (we[k] && inr) begin
                mmem[k][a] = di[k];
                mkn[k][a]  = 1'b1;
            end
        end
        if (mbusy[k]) begin
            mmem[k][mcnt[k]] = '0;
            mkn[k][mcnt[k]]  = 1'b1;
            if (mcnt[k] == P_DP[k] - 1) mbusy[k] = 1'b0;
            mcnt[k]++;
        end
        if (r.v) begin
            mhold[k] = r.d;
            mhk[k]   = r.chk;
        end
        sbq[k].push_back(r);
    endtask

    task automatic check_all();
        exp_t e;
        for (int k = 0; k < N; k++) begin
            nchk++;
            if (sbq[k].size() == 0) begin
                nerr++;
                $error("FAIL sbq_empty u%0d got 0 entries want 1", k);
                continue;
            end
            e = sbq[k].pop_front();
            assert (dv[k] === e.v) else begin
                nerr++;
                $error("FAIL do_valid u%0d got %b want %b", k, dv[k], e.v);
            end
            if (e.chk) begin
                nchk++;
                assert (dout[k] === e.d) else begin
                    nerr++;
                    $error("FAIL do u%0d got %h want %h", k, dout[k], e.d);
                end
            end
            nchk++;
            assert (busy[k] === mbusy[k]) else begin
                nerr++;
                $error("FAIL busy u%0d got %b want %b", k, busy[k], mbusy[k]);
            end
        end
    endtask

    task automatic cycle();
        for (int k = 0; k < N; k++) model_edge(k);
        @(posedge clk);
        #1;
        check_all();
        rst = '0;
        en  = '0;
        we  = '0;
    endtask

    task automatic drive_all(bit r, bit e, bit w, int a, logic [3:0] d);
        for (int k = 0; k < N; k++) begin
            rst[k]  = r;
            en[k]   = e;
            we[k]   = w;
            addr[k] = 5'(a);
            di[k]   = d;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = '0;
        en   = '0;
        we   = '0;
        addr = '0;
        di   = '0;
        for (int k = 0; k < N; k++) begin
            mhold[k] = '0;
            mhk[k]   = 1'b0;
            mbusy[k] = 1'b0;
            mcnt[k]  = 0;
            for (int i = 0; i < 32; i++) mkn[k][i] = 1'b0;
        end

        drive_all(1, 0, 0, 0, 4'h0);
        cycle();
        cycle();

        for (int a = 0; a < 32; a++) begin
            drive_all(0, 1, 1, a, 4'(~a));
            cycle();
        end
        for (int a = 0; a < 32; a++) begin
            drive_all(0, 1, 1, a, 4'(a));
            cycle();
        end
        for (int a = 0; a < 32; a++) begin
            drive_all(0, 1, 0, a, 4'h0);
            cycle();
        end

        drive_all(0, 1, 1, 6, 4'h3);
        cycle();
        drive_all(0, 1, 0, 6, 4'h0);
        cycle();
        drive_all(0, 1, 1, 5, 4'hA);
        cycle();
        drive_all(0, 1, 0, 5, 4'h0);
        cycle();

        drive_all(0, 1, 1, 7, 4'h6);
        cycle();
        cycle();
        drive_all(0, 1, 0, 7, 4'h0);
        cycle();
        cycle();
        cycle();

        for (int i = 0; i < 6; i++) begin
            drive_all(0, 0, 1, i * 3, 4'(i + 8));
            cycle();
        end
        drive_all(1, 1, 1, 3, 4'h5);
        cycle();
        drive_all(0, 1, 0, 3, 4'h0);
        cycle();

        drive_all(0, 1, 1, 25, 4'h9);
        cycle();
        drive_all(0, 1, 0, 25, 4'h0);
        cycle();

        repeat (34) cycle();
        for (int a = 0; a < 32; a++) begin
            drive_all(0, 1, 1, a, 4'hF);
            cycle();
        end
        drive_all(1, 0, 0, 0, 4'h0);
        cycle();
        for (int i = 0; i < 9; i++) begin
            drive_all(0, 1, 1, i, 4'h7);
            cycle();
        end
        drive_all(1, 0, 0, 0, 4'h0);
        cycle();
        bcnt = int'(busy[4]);
        for (int i = 0; i < 40; i++) begin
            drive_all(0, 1, 0, i % 32, 4'h0);
            cycle();
            if (busy[4]) bcnt++;
        end
        nchk++;
        assert (bcnt === 32) else begin
            nerr++;
            $error("FAIL busy_len got %0d want 32", bcnt);
        end
        for (int a = 0; a < 32; a++) begin
            drive_all(0, 1, 0, a, 4'h0);
            cycle();
        end
        cycle();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
